// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer: owns the fetch PC for a 5-stage core. Advances the PC to
// the core-computed next address when the hazard unit allows it, holds on
// stalls and debug freeze, drains the pipeline once END_ADDR is reached, and
// traps misaligned targets or runaway stalls in a sticky error state.
// Optional feature macro: PC_PERF_CNT_EN enables the fetch/stall counters;
// without it fetch_cnt and stall_cnt read as zero.
module pc_fetch_sequencer #(
    parameter logic [31:0] RESET_ADDR   = 32'h0000_0000,
    parameter logic [31:0] END_ADDR     = 32'h0000_0100,
    parameter int          DRAIN_CYCLES = 4,
    parameter int          STALL_MAX    = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc_next,
    input  logic        pc_write,
    input  logic        hold,
    output logic [31:0] pc,
    output logic        busy,
    output logic        done,
    output logic        stall_err,
    output logic [31:0] fetch_cnt,
    output logic [31:0] stall_cnt
);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_DRAIN = 2'd1,
        S_DONE  = 2'd2,
        S_ERR   = 2'd3
    } state_e;

    // Drain counter starts one below the wait so DONE lands DRAIN_CYCLES edges
    // after entering DRAIN; a stall trips when the run count already holds
    // STALL_MAX-1 and one more stall arrives.
    localparam logic [7:0] DRAIN_LOAD = 8'(DRAIN_CYCLES - 1);
    localparam logic [7:0] STALL_LAST = 8'(STALL_MAX - 1);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [7:0]  drain_q, drain_d;
    logic [7:0]  run_q, run_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        fetch_inc, stall_inc;

    // Next-state, PC and internal counter decisions for the sequencer FSM.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        drain_d   = drain_q;
        run_d     = run_q;
        fetch_inc = 1'b0;
        stall_inc = 1'b0;
        case (state_q)
            S_RUN: begin
                if (pc_q == END_ADDR) begin
                    // End of program outranks everything, including a stall overflow.
                    state_d = S_DRAIN;
                    drain_d = DRAIN_LOAD;
                end else if (hold) begin
                    // Debug freeze: nothing moves, not even the stall-run count.
                end else if (pc_write) begin
                    if (pc_next[1:0] == 2'b00) begin
                        pc_d      = pc_next;
                        fetch_inc = 1'b1;
                        run_d     = 8'd0;
                    end else begin
                        state_d = S_ERR;
                    end
                end else begin
                    stall_inc = 1'b1;
                    run_d     = run_q + 8'd1;
                    if (run_q == STALL_LAST) state_d = S_ERR;
                end
            end
            S_DRAIN: begin
                if (drain_q == 8'd0) state_d = S_DONE;
                else                 drain_d = drain_q - 8'd1;
            end
            default: ;
        endcase
        busy_d = (state_d == S_RUN) || (state_d == S_DRAIN);
        done_d = (state_d == S_DONE);
        err_d  = (state_d == S_ERR);
    end

    // State, PC and registered status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_RUN;
            pc_q    <= RESET_ADDR;
            drain_q <= 8'd0;
            run_q   <= 8'd0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            drain_q <= drain_d;
            run_q   <= run_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign pc        = pc_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign stall_err = err_q;

`ifdef PC_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, stall_cnt_q;

    // Saturating performance counters; they only move in RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt_q <= 32'd0;
            stall_cnt_q <= 32'd0;
        end else begin
            if (fetch_inc && (fetch_cnt_q != 32'hFFFF_FFFF)) fetch_cnt_q <= fetch_cnt_q + 32'd1;
            if (stall_inc && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign fetch_cnt = fetch_cnt_q;
    assign stall_cnt = stall_cnt_q;
`else
    logic perf_unused;
    assign perf_unused = fetch_inc ^ stall_inc;
    assign fetch_cnt   = 32'h0;
    assign stall_cnt   = 32'h0;
`endif

endmodule

// File: doc/pc_fetch_sequencer.md
# pc_fetch_sequencer

Program-counter and fetch sequencer sitting directly upstream of the pipelined CPU core. Owns the PC register that drives the core's instruction address, advances it to the core-computed next address when the core's hazard unit permits, and holds it during load-use stalls. Detects end of program, drains the 5-stage pipeline, and flags pathological stalls or misaligned addresses. Optionally keeps fetch/stall performance counters.

## Interface
- RESET_ADDR, 32'h0000_0000: PC value after reset.
- END_ADDR, 32'h0000_0100: word address at which fetching stops; the program guarantees the word at END_ADDR is 32'h0 (NOP).
- DRAIN_CYCLES, 4: cycles waited after reaching END_ADDR so in-flight instructions reach write-back; legal range 1..255.
- STALL_MAX, 8: consecutive stall cycles that trigger a stall error; legal range 2..255.

- clk  input  1  rising-edge clock, the same clock as the CPU core.
- rst_n  input  1  asynchronous, active-low reset.
- pc_next  input  32  next sequential address from the core's fetch adder.
- pc_write  input  1  PC update enable from the core; low means hazard stall.
- hold  input  1  debug freeze; while high the PC does not advance.
- pc  output  32  current fetch address to the core's instruction memory.
- busy  output  1  high in RUN and DRAIN.
- done  output  1  high in DONE.
- stall_err  output  1  sticky error flag, high in ERR.
- fetch_cnt  output  32  accepted PC advances.
- stall_cnt  output  32  cycles with pc_write=0 while in RUN.

## Operation
- States: RUN, DRAIN, DONE, ERR. Reset enters RUN.
- RUN, with evaluation in this priority order:
  - pc == END_ADDR: go to DRAIN, PC held, drain counter loaded with DRAIN_CYCLES-1.
  - hold=1: PC held. No counters change and the stall-run counter is unchanged.
  - pc_write=1 and pc_next[1:0]==0: pc <= pc_next, fetch_cnt+1, stall-run cleared.
  - pc_write=1 and pc_next[1:0]!=0: go to ERR, PC held.
  - pc_write=0: PC held, stall_cnt+1, stall-run+1. When stall-run would reach STALL_MAX, go to ERR.
- DRAIN: PC held at END_ADDR. pc_write, hold and pc_next are ignored. The counter decrements each cycle; when it is 0, go to DONE.
- DONE: terminal until reset. PC held.
- ERR: terminal until reset. PC held at the offending value. stall_err=1.
- The 8-bit stall-run counter is internal.
- pc_next is loaded as-is. Low-byte wrap-around performed by the core is accepted, with no range check beyond alignment.

## Timing
- All outputs are registered.
- Reset values: pc=RESET_ADDR, busy=1, done=0, stall_err=0, fetch_cnt=0, stall_cnt=0. Internal stall-run=0, drain counter=0.
- Combinational loop: pc feeds the core, and the core returns pc_next/pc_write in the same cycle. The PC update lands on the next rising edge, so there is one cycle per fetch.
- A load-use stall (pc_write low for 1 cycle) holds the PC for exactly 1 cycle.
- pc first equals END_ADDR at edge N: the DRAIN transition happens at edge N+1, and done rises at edge N+1+DRAIN_CYCLES.
- On entering DRAIN, busy stays 1. On entering DONE or ERR, busy falls on the same edge that raises done or stall_err.
- If rst_n is asserted mid-operation, all state returns to reset values immediately (asynchronously). The core's pipeline registers are not reset by this block.
- Simultaneous hold=1 and pc_write=0 counts as hold: no stall is counted.
- If END_ADDR is reached on the same edge as a stall-run overflow, DRAIN wins, because the pc==END_ADDR check has highest priority.

## Configuration
- PC_PERF_CNT_EN defined: fetch_cnt and stall_cnt are implemented. Both saturate at 32'hFFFF_FFFF and freeze outside RUN.
- PC_PERF_CNT_EN undefined: both ports are tied to 32'h0. The counter logic is removed and the port list is unchanged.

## Test plan
- Reset release with RESET_ADDR=0 and the core returning pc+4 with pc_write=1 -> pc steps 0,4,8,… one per cycle; fetch_cnt equals cycles since reset.
- pc_write low for 1 cycle at pc=0x10 -> pc stays 0x10 for 2 cycles then goes to 0x14; stall_cnt=1; no error.
- pc_write held low for 8 cycles at STALL_MAX=8 -> stall_err=1 and busy=0 on the 8th stall edge; pc frozen afterwards.
- Run to END_ADDR=0x20 with DRAIN_CYCLES=4 -> pc held at 0x20; done rises 5 edges after pc first equals 0x20; later pc_write toggling has no effect.
- pc_next=0x0000_0006 with pc_write=1 -> ERR on that edge with pc unchanged; separately, hold=1 for 3 cycles -> pc and both counters unchanged.
- rst_n pulsed low while in DRAIN or ERR -> pc=RESET_ADDR, done=0, stall_err=0, counters 0 immediately, without waiting for a clock edge.
